// File: rtl/ram_pkg.sv
// Shared FSM encoding and operation-mode constants for the RAM copy/fill engine.
// No logic here; imported by ram_copier and anything that decodes its state.
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram.sv
// Single-port word RAM: synchronous write, registered read (data one cycle after address).
// Always ready; no backpressure, read-before-write on a same-address access.
module ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (load) mem[address] <= data_in;
    data_out <= mem[address];
  end

endmodule

// File: rtl/ram_copier.sv
// Copies (2 cycles/word, read then write) or fills (1 cycle/word) an ascending RAM range; done pulses
// one cycle after the last write. No backpressure: start is ignored while busy, inputs latched once.
module ram_copier
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] pattern,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_in,
  output logic                  ram_load,
  input  logic [DATA_WIDTH-1:0] ram_out
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] src_r;
  logic [ADDR_WIDTH-1:0] dst_r;
  logic [ADDR_WIDTH:0]   len_r;
  logic                  mode_r;
  logic [DATA_WIDTH-1:0] pattern_r;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_inc;

  assign count_inc = count + 1'b1;

  // In copy mode the word read during RD arrives on ram_out during WR and goes straight back out.
  assign ram_in = ram_load ? ((mode_r == MODE_FILL) ? pattern_r : ram_out) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      src_r       <= '0;
      dst_r       <= '0;
      len_r       <= '0;
      mode_r      <= MODE_COPY;
      pattern_r   <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_load    <= 1'b0;
      ram_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_r     <= src;
            dst_r     <= dst;
            len_r     <= len;
            mode_r    <= mode;
            pattern_r <= pattern;
            count     <= '0;
            busy      <= 1'b1;
            if (len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (mode == MODE_FILL) begin
              state       <= WR;
              ram_load    <= 1'b1;
              ram_address <= dst;
            end else begin
              state       <= RD;
              ram_address <= src;
            end
          end
        end
        RD: begin
          state       <= WR;
          ram_load    <= 1'b1;
          ram_address <= dst_r + count[ADDR_WIDTH-1:0];
        end
        WR: begin
          count <= count_inc;
          if (count_inc == len_r) begin
            state    <= FIN;
            ram_load <= 1'b0;
            done     <= 1'b1;
          end else if (mode_r == MODE_FILL) begin
            ram_address <= dst_r + count_inc[ADDR_WIDTH-1:0];
          end else begin
            state       <= RD;
            ram_load    <= 1'b0;
            ram_address <= src_r + count_inc[ADDR_WIDTH-1:0];
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          ram_load <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_copier.sv
// Bench for ram_copier driving a real RAM; a word-array model predicts memory contents,
// write sequences and completion timing from the copy/fill rules.
module tb_ram_copier;

  localparam int BOUND = 700;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [7:0]  src;
  logic [7:0]  dst;
  logic [8:0]  len;
  logic [15:0] pattern;
  logic        busy;
  logic        done;
  logic [7:0]  ram_address;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;

  // Bench-side RAM port used for preload and readback while the copier is idle.
  logic        tb_own;
  logic [7:0]  tb_addr;
  logic [15:0] tb_wdata;
  logic        tb_load;

  logic [7:0]  m_addr;
  logic [15:0] m_data;
  logic        m_load;

  assign m_addr = tb_own ? tb_addr  : ram_address;
  assign m_data = tb_own ? tb_wdata : ram_in;
  assign m_load = tb_own ? tb_load  : ram_load;

  ram_copier dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .pattern     (pattern),
    .busy        (busy),
    .done        (done),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_out     (ram_out)
  );

  ram u_ram (
    .clk      (clk),
    .address  (m_addr),
    .data_in  (m_data),
    .load     (m_load),
    .data_out (ram_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] model [256];
  logic [15:0] rd    [256];
  logic [7:0]  exp_a [$];
  logic [15:0] exp_d [$];
  logic [7:0]  obs_a [$];
  logic [15:0] obs_d [$];

  int         done_cyc, ndone, nbusy, first_idle, nloads, bad_in;
  logic [7:0] fin_addr;

  // Sequential word-by-word semantics, including overlap and modulo-256 wrap.
  task automatic model_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input int l, input logic [15:0] p);
    exp_a.delete();
    exp_d.delete();
    for (int i = 0; i < l; i++) begin
      logic [7:0]  a;
      logic [15:0] v;
      a = 8'((int'(d) + i) % 256);
      v = m ? p : model[(int'(s) + i) % 256];
      model[a] = v;
      exp_a.push_back(a);
      exp_d.push_back(v);
    end
  endtask

  function automatic int exp_done_cycle(input logic m, input int l);
    if (l == 0) return 1;
    return m ? l + 1 : 2 * l + 1;
  endfunction

  task automatic write_word(input logic [7:0] a, input logic [15:0] v);
    @(negedge clk);
    tb_own   = 1'b1;
    tb_addr  = a;
    tb_wdata = v;
    tb_load  = 1'b1;
    @(posedge clk);
    #1 tb_load = 1'b0;
    model[a] = v;
  endtask

  task automatic read_mem();
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      tb_own  = 1'b1;
      tb_load = 1'b0;
      tb_addr = 8'(a);
      @(posedge clk);
      #1 rd[a] = ram_out;
    end
  endtask

  // Launches one operation and records what the copier did, cycle by cycle after the start edge.
  task automatic run_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                        input logic [8:0] l, input logic [15:0] p, input int restart);
    obs_a.delete();
    obs_d.delete();
    done_cyc = 0; ndone = 0; nbusy = 0; first_idle = 0; nloads = 0; bad_in = 0; fin_addr = '0;
    @(negedge clk);
    tb_own = 1'b0; tb_load = 1'b0;
    mode = m; src = s; dst = d; len = l; pattern = p; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= BOUND; c++) begin
      @(negedge clk);
      if (busy) nbusy++;
      else if (first_idle == 0) first_idle = c;
      if (done) begin ndone++; done_cyc = c; fin_addr = ram_address; end
      if (ram_load) begin
        nloads++;
        obs_a.push_back(ram_address);
        obs_d.push_back(ram_in);
      end else if (ram_in !== 16'h0) bad_in++;
      start   = (c == restart);
      src     = 8'($urandom);
      dst     = 8'($urandom);
      len     = 9'($urandom);
      mode    = 1'($urandom);
      pattern = 16'($urandom);
      if (done_cyc != 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; pattern = '0;
    tb_own = 1'b1; tb_addr = '0; tb_wdata = '0; tb_load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (ram_load !== 1'b0) begin miscompares++; $display("FAIL reset_load: got %b want 0", ram_load); end
    vectors++; if (ram_address !== 8'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 00", ram_address); end
    vectors++; if (ram_in !== 16'h0) begin miscompares++; $display("FAIL reset_in: got %h want 0000", ram_in); end
    rst_n = 1'b1;
    for (int a = 0; a < 256; a++) write_word(8'(a), 16'($urandom));
  endtask

  task automatic test_copy();
    logic [15:0] w [4];
    w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) write_word(8'(8'h10 + i), w[i]);
    model_op(1'b0, 8'h10, 8'h80, 4, 16'h0);
    run_op(1'b0, 8'h10, 8'h80, 9'd4, 16'h0, 0);
    vectors++; if (done_cyc !== 9) begin miscompares++; $display("FAIL copy_done_cycle: got %0d want 9", done_cyc); end
    vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL copy_done_count: got %0d want 1", ndone); end
    vectors++; if (nbusy !== 9) begin miscompares++; $display("FAIL copy_busy_cycles: got %0d want 9", nbusy); end
    vectors++; if (first_idle !== 10) begin miscompares++; $display("FAIL copy_idle_cycle: got %0d want 10", first_idle); end
    vectors++; if (obs_a.size() !== 4) begin miscompares++; $display("FAIL copy_writes: got %0d want 4", obs_a.size()); end
    for (int i = 0; i < obs_a.size() && i < 4; i++) begin
      vectors++;
      if (obs_a[i] !== 8'(8'h80 + i) || obs_d[i] !== w[i]) begin
        miscompares++;
        $display("FAIL copy_write[%0d]: got %h=%h want %h=%h", i, obs_a[i], obs_d[i], 8'(8'h80 + i), w[i]);
      end
    end
    read_mem();
    for (int a = 0; a < 256; a++) begin
      vectors++;
      if (rd[a] !== model[a]) begin miscompares++; $display("FAIL copy_mem[%h]: got %h want %h", a, rd[a], model[a]); end
    end
  endtask

  task automatic test_fill_wrap();
    logic [7:0] wa [4];
    wa = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    model_op(1'b1, 8'h00, 8'hFE, 4, 16'hBEEF);
    run_op(1'b1, 8'($urandom), 8'hFE, 9'd4, 16'hBEEF, 0);
    vectors++; if (nloads !== 4) begin miscompares++; $display("FAIL fill_loads: got %0d want 4", nloads); end
    vectors++; if (done_cyc !== 5) begin miscompares++; $display("FAIL fill_done_cycle: got %0d want 5", done_cyc); end
    vectors++; if (fin_addr !== 8'h01) begin miscompares++; $display("FAIL fill_fin_addr: got %h want 01", fin_addr); end
    for (int i = 0; i < obs_a.size() && i < 4; i++) begin
      vectors++;
      if (obs_a[i] !== wa[i] || obs_d[i] !== 16'hBEEF) begin
        miscompares++;
        $display("FAIL fill_write[%0d]: got %h=%h want %h=beef", i, obs_a[i], obs_d[i], wa[i]);
      end
    end
    read_mem();
    for (int a = 0; a < 256; a++) begin
      vectors++;
      if (rd[a] !== model[a]) begin miscompares++; $display("FAIL fill_mem[%h]: got %h want %h", a, rd[a], model[a]); end
    end
  endtask

  task automatic test_len_zero();
    run_op(1'($urandom), 8'($urandom), 8'($urandom), 9'd0, 16'($urandom), 0);
    vectors++; if (nloads !== 0) begin miscompares++; $display("FAIL zero_loads: got %0d want 0", nloads); end
    vectors++; if (done_cyc !== 1) begin miscompares++; $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); end
    vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL zero_done_count: got %0d want 1", ndone); end
    vectors++; if (first_idle !== 2) begin miscompares++; $display("FAIL zero_idle_cycle: got %0d want 2", first_idle); end
  endtask

  task automatic test_overlap();
    logic [15:0] va, vb, vc;
    va = 16'hA0A0; vb = 16'hB1B1; vc = 16'hC2C2;
    write_word(8'h00, va); write_word(8'h01, vb); write_word(8'h02, vc);
    model_op(1'b0, 8'h00, 8'h01, 3, 16'h0);
    run_op(1'b0, 8'h00, 8'h01, 9'd3, 16'h0, 0);
    read_mem();
    for (int a = 1; a <= 3; a++) begin
      vectors++;
      if (rd[a] !== va) begin miscompares++; $display("FAIL overlap_word[%0d]: got %h want %h", a, rd[a], va); end
    end
    vectors++; if (rd[0] !== va) begin miscompares++; $display("FAIL overlap_src: got %h want %h", rd[0], va); end
    for (int a = 0; a < 256; a++) begin
      vectors++;
      if (rd[a] !== model[a]) begin miscompares++; $display("FAIL overlap_mem[%h]: got %h want %h", a, rd[a], model[a]); end
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] s, d;
    s = 8'($urandom); d = 8'($urandom);
    model_op(1'b0, s, d, 4, 16'h0);
    run_op(1'b0, s, d, 9'd4, 16'h0, 3);
    vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL restart_done_count: got %0d want 1", ndone); end
    vectors++; if (done_cyc !== 9) begin miscompares++; $display("FAIL restart_done_cycle: got %0d want 9", done_cyc); end
    vectors++; if (nloads !== 4) begin miscompares++; $display("FAIL restart_loads: got %0d want 4", nloads); end
    read_mem();
    for (int a = 0; a < 256; a++) begin
      vectors++;
      if (rd[a] !== model[a]) begin miscompares++; $display("FAIL restart_mem[%h]: got %h want %h", a, rd[a], model[a]); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      logic        m;
      logic [7:0]  s, d;
      logic [15:0] p;
      int          l, ed;
      m = 1'($urandom); s = 8'($urandom); d = 8'($urandom); p = 16'($urandom);
      l = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 16) : $urandom_range(0, 256);
      ed = exp_done_cycle(m, l);
      model_op(m, s, d, l, p);
      run_op(m, s, d, 9'(l), p, 0);
      vectors++; if (done_cyc !== ed) begin miscompares++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", n, done_cyc, ed); end
      vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL rand%0d_done_count: got %0d want 1", n, ndone); end
      vectors++; if (nbusy !== ed) begin miscompares++; $display("FAIL rand%0d_busy_cycles: got %0d want %0d", n, nbusy, ed); end
      vectors++; if (nloads !== l) begin miscompares++; $display("FAIL rand%0d_loads: got %0d want %0d", n, nloads, l); end
      vectors++; if (bad_in !== 0) begin miscompares++; $display("FAIL rand%0d_idle_data: got %0d want 0", n, bad_in); end
      if (l > 0) begin
        vectors++;
        if (fin_addr !== exp_a[l-1]) begin miscompares++; $display("FAIL rand%0d_fin_addr: got %h want %h", n, fin_addr, exp_a[l-1]); end
      end
      for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
        vectors++;
        if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin
          miscompares++;
          $display("FAIL rand%0d_write[%0d]: got %h=%h want %h=%h", n, i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]);
        end
      end
      read_mem();
      for (int a = 0; a < 256; a++) begin
        vectors++;
        if (rd[a] !== model[a]) begin miscompares++; $display("FAIL rand%0d_mem[%h]: got %h want %h", n, a, rd[a], model[a]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  d;
    logic [15:0] p;
    int          spurious;
    d = 8'($urandom); p = 16'($urandom);
    spurious = 0;
    @(negedge clk);
    tb_own = 1'b0; tb_load = 1'b0;
    mode = 1'b1; src = 8'($urandom); dst = d; len = 9'd256; pattern = p; start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    // Reset lands just after the second word commits, while the write strobe is still up.
    #1;
    vectors++; if (ram_load !== 1'b1) begin miscompares++; $display("FAIL midrst_load_before: got %b want 1", ram_load); end
    rst_n = 1'b0;
    #1;
    vectors++; if (ram_load !== 1'b0) begin miscompares++; $display("FAIL midrst_load_async: got %b want 0", ram_load); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
    vectors++; if (ram_address !== 8'h0) begin miscompares++; $display("FAIL midrst_addr: got %h want 00", ram_address); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 3) rst_n = 1'b1;
      if (done !== 1'b0 || ram_load !== 1'b0) spurious++;
    end
    vectors++; if (spurious !== 0) begin miscompares++; $display("FAIL midrst_no_done: got %0d active cycles want 0", spurious); end
    model[d] = p;
    model[8'(d + 8'd1)] = p;
    read_mem();
    for (int a = 0; a < 256; a++) begin
      vectors++;
      if (rd[a] !== model[a]) begin miscompares++; $display("FAIL midrst_mem[%h]: got %h want %h", a, rd[a], model[a]); end
    end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill_wrap();
    test_len_zero();
    test_overlap();
    test_start_ignored();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_copier.md
RAM_COPIER -- requirements
Module: ram_copier

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the RAM address width (256 words).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning the RAM word width.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: asynchronous, active-low.
REQ-005 Port start  input  1  requests an operation; it is sampled only in IDLE.
REQ-006 Port mode  input  1  selects the operation: 0 = copy, 1 = fill.
REQ-007 Port src  input  ADDR_WIDTH  is the copy source base address.
REQ-008 Port dst  input  ADDR_WIDTH  is the destination base address.
REQ-009 Port len  input  ADDR_WIDTH+1  is the word count, 0..256.
REQ-010 Port pattern  input  DATA_WIDTH  is the fill value.
REQ-011 Port busy  output  1  is high in every non-IDLE state.
REQ-012 Port done  output  1  is a one-cycle completion pulse.
REQ-013 Port ram_address  output  ADDR_WIDTH  drives the RAM address.
REQ-014 Port ram_in  output  DATA_WIDTH  drives the RAM write data.
REQ-015 Port ram_load  output  1  drives the RAM write enable.
REQ-016 Port ram_out  input  DATA_WIDTH  is the RAM read data; it is valid in the cycle after its address is presented.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, RD, WR and FIN; all outputs SHALL be Moore outputs decoded from state and registers.
REQ-018 In IDLE, start=1 SHALL latch src, dst, len, mode and pattern, and reset the word counter to 0.
REQ-019 From IDLE with start=1, the next state SHALL be FIN if len=0, else WR if mode=1, else RD.
REQ-020 In RD, ram_address SHALL equal src+count, ram_load SHALL be 0, and the next state SHALL be WR.
REQ-021 In WR, ram_address SHALL equal dst+count and ram_load SHALL be 1.
REQ-022 In WR, ram_in SHALL equal ram_out in copy mode and the latched pattern in fill mode.
REQ-023 On leaving WR, count SHALL increment, and the next state SHALL be FIN if count+1 = len, else RD (copy) or WR (fill).
REQ-024 Throughput SHALL be 2 cycles per word in copy mode and 1 cycle per word in fill mode.
REQ-025 In FIN, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-026 Address arithmetic SHALL be modulo 2^ADDR_WIDTH: 255+1 wraps to 0.
REQ-027 Copies SHALL be strictly ascending, word by word; with overlapping ranges, the result SHALL be exactly what that sequential order produces.
REQ-028 start asserted while busy SHALL be ignored, and input changes after the latch cycle SHALL have no effect.
REQ-029 In IDLE and FIN, ram_load SHALL be 0, ram_address SHALL hold its last value, and ram_in SHALL be 0.

Reset
REQ-030 While rst_n=0, the state SHALL be IDLE and busy, done, ram_load, ram_address, ram_in and count SHALL all be 0.
REQ-031 Reset mid-operation SHALL deassert ram_load immediately (asynchronously), abort the operation without generating done, and leave already-written words intact.

Structure
REQ-032 The FSM state encoding and the mode constants (COPY=0, FILL=1) SHALL live in a shared package, ram_pkg.
REQ-033 The block SHALL have no sub-modules; the bench SHALL instantiate ram_copier together with the existing 256x16 RAM block.

Verification
REQ-034 Copy, src=0x10, dst=0x80, len=4, words 0x1111..0x4444 -> M[0x80..0x83] equal those words, done at cycle 9 after the start edge, busy high for cycles 1-9.
REQ-035 Fill, dst=0xFE, len=4, pattern=0xBEEF -> M[0xFE], M[0xFF], M[0x00], M[0x01] = 0xBEEF, 4 consecutive ram_load cycles.
REQ-036 len=0 -> no ram_load at all, done one cycle after start, then IDLE.
REQ-037 Overlapping copy, src=0x00, dst=0x01, len=3, M[0..2]=A,B,C -> M[1..3]=A,A,A.
REQ-038 start pulsed again at cycle 3 of a len=4 copy -> ignored, exactly one done pulse.
REQ-039 rst_n=0 during the second WR of a len=256 fill -> ram_load 0 at once, no done, M[dst] and M[dst+1] written and nothing beyond them.
